// File: rtl/fpu_ss_issue_buffer.sv
// Offload issue buffer: circular FIFO of C-requests feeding the FPU, with an FP register
// scoreboard and RAW/WAW hazard stall present only when FPU_SS_SCOREBOARD_EN is defined.
module fpu_ss_issue_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NUM_RS = 3,
  parameter int unsigned XLEN   = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           c_q_valid_i,
  output logic                           c_q_ready_o,
  input  logic [XLEN-1:0]                c_q_instr_data_i,
  input  logic [XLEN-1:0]                c_q_hart_id_i,
  input  logic [NUM_RS-1:0][XLEN-1:0]    c_q_rs_i,
  input  logic                           flush_i,
  output logic                           issue_valid_o,
  input  logic                           issue_ready_i,
  output logic [XLEN-1:0]                issue_instr_o,
  output logic [XLEN-1:0]                issue_hart_id_o,
  output logic [NUM_RS-1:0][XLEN-1:0]    issue_rs_o,
  input  logic [2:0]                     head_fpr_use_i,
  input  logic                           head_rd_is_fp_i,
  input  logic                           wb_valid_i,
  input  logic [4:0]                     wb_addr_i,
  output logic [$clog2(DEPTH):0]         usage_o,
  output logic [31:0]                    fpr_busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned UW = AW + 1;
  localparam logic [AW:0] Full = UW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   usage_q, usage_d;

  logic [XLEN-1:0]             instr_q [DEPTH];
  logic [XLEN-1:0]             hart_q  [DEPTH];
  logic [NUM_RS-1:0][XLEN-1:0] rs_q    [DEPTH];

  logic push, pop, stall;

  // Ready ignores a same-cycle issue, so a full buffer never accepts a push.
  assign c_q_ready_o   = (usage_q != Full) && !flush_i;
  assign push          = c_q_valid_i && c_q_ready_o;
  assign issue_valid_o = (usage_q != '0) && !stall && !flush_i;
  assign pop           = issue_valid_o && issue_ready_i;

  assign usage_o         = usage_q;
  assign issue_instr_o   = instr_q[rd_ptr_q];
  assign issue_hart_id_o = hart_q[rd_ptr_q];
  assign issue_rs_o      = rs_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   usage_d = usage_q + UW'(1);
        2'b01:   usage_d = usage_q - UW'(1);
        default: usage_d = usage_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        hart_q[i]  <= '0;
        rs_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= c_q_instr_data_i;
      hart_q[wr_ptr_q]  <= c_q_hart_id_i;
      rs_q[wr_ptr_q]    <= c_q_rs_i;
    end
  end

`ifdef FPU_SS_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;
  logic [4:0]  rd, rs1, rs2, rs3;

  assign rd  = issue_instr_o[11:7];
  assign rs1 = issue_instr_o[19:15];
  assign rs2 = issue_instr_o[24:20];
  assign rs3 = issue_instr_o[31:27];

  assign stall = (head_fpr_use_i[0] && busy_q[rs1]) ||
                 (head_fpr_use_i[1] && busy_q[rs2]) ||
                 (head_fpr_use_i[2] && busy_q[rs3]) ||
                 (head_rd_is_fp_i   && busy_q[rd]);

  // Set is applied after clear so an issue wins over a same-address writeback.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i)               busy_d[wb_addr_i] = 1'b0;
    if (pop && head_rd_is_fp_i)   busy_d[rd]        = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign fpr_busy_o = busy_q;
`else
  logic unused_sb;
  assign unused_sb  = ^{head_fpr_use_i, head_rd_is_fp_i, wb_valid_i, wb_addr_i};
  assign stall      = 1'b0;
  assign fpr_busy_o = '0;
`endif

endmodule

// File: tb/tb_fpu_ss_issue_buffer.sv
// Self-checking bench for fpu_ss_issue_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fpu_ss_issue_buffer;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NUM_RS = 3;
  localparam int unsigned XLEN   = 32;
`ifdef FPU_SS_SCOREBOARD_EN
  localparam bit SbEn = 1'b1;
`else
  localparam bit SbEn = 1'b0;
`endif

  typedef struct {
    logic [XLEN-1:0]             instr;
    logic [XLEN-1:0]             hart;
    logic [NUM_RS-1:0][XLEN-1:0] rs;
    logic [2:0]                  use_fp;
    logic                        rd_fp;
  } entry_t;

  logic                        clk, rst_n;
  logic                        c_q_valid_i, c_q_ready_o;
  logic [XLEN-1:0]             c_q_instr_data_i, c_q_hart_id_i;
  logic [NUM_RS-1:0][XLEN-1:0] c_q_rs_i;
  logic                        flush_i, issue_valid_o, issue_ready_i;
  logic [XLEN-1:0]             issue_instr_o, issue_hart_id_o;
  logic [NUM_RS-1:0][XLEN-1:0] issue_rs_o;
  logic [2:0]                  head_fpr_use_i;
  logic                        head_rd_is_fp_i, wb_valid_i;
  logic [4:0]                  wb_addr_i;
  logic [$clog2(DEPTH):0]      usage_o;
  logic [31:0]                 fpr_busy_o;

  fpu_ss_issue_buffer #(.DEPTH(DEPTH), .NUM_RS(NUM_RS), .XLEN(XLEN)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .c_q_valid_i      (c_q_valid_i),
    .c_q_ready_o      (c_q_ready_o),
    .c_q_instr_data_i (c_q_instr_data_i),
    .c_q_hart_id_i    (c_q_hart_id_i),
    .c_q_rs_i         (c_q_rs_i),
    .flush_i          (flush_i),
    .issue_valid_o    (issue_valid_o),
    .issue_ready_i    (issue_ready_i),
    .issue_instr_o    (issue_instr_o),
    .issue_hart_id_o  (issue_hart_id_o),
    .issue_rs_o       (issue_rs_o),
    .head_fpr_use_i   (head_fpr_use_i),
    .head_rd_is_fp_i  (head_rd_is_fp_i),
    .wb_valid_i       (wb_valid_i),
    .wb_addr_i        (wb_addr_i),
    .usage_o          (usage_o),
    .fpr_busy_o       (fpr_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     failures = 0;
  entry_t q[$];
  logic [31:0] busy = '0;
  entry_t nxt;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic entry_t mk(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [4:0] s3, input logic [2:0] u, input logic rf);
    entry_t e;
    e.instr        = $urandom;
    e.instr[11:7]  = rd;
    e.instr[19:15] = s1;
    e.instr[24:20] = s2;
    e.instr[31:27] = s3;
    e.hart         = $urandom;
    for (int i = 0; i < NUM_RS; i++) e.rs[i] = $urandom;
    e.use_fp = u;
    e.rd_fp  = rf;
    return e;
  endfunction

  function automatic entry_t mk_plain();
    return mk(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 3'b000, 1'b0);
  endfunction

  // One clock cycle: drive payload and head decode, check at negedge, update model at posedge.
  task automatic tick();
    logic        stall, exp_valid, push, pop;
    logic [31:0] bnext;
    c_q_instr_data_i = nxt.instr;
    c_q_hart_id_i    = nxt.hart;
    c_q_rs_i         = nxt.rs;
    if (q.size() > 0) begin
      head_fpr_use_i  = q[0].use_fp;
      head_rd_is_fp_i = q[0].rd_fp;
    end else begin
      head_fpr_use_i  = 3'b000;
      head_rd_is_fp_i = 1'b0;
    end
    @(negedge clk);
    stall = 1'b0;
    if (SbEn && q.size() > 0) begin
      stall = (q[0].use_fp[0] && busy[q[0].instr[19:15]]) ||
              (q[0].use_fp[1] && busy[q[0].instr[24:20]]) ||
              (q[0].use_fp[2] && busy[q[0].instr[31:27]]) ||
              (q[0].rd_fp     && busy[q[0].instr[11:7]]);
    end
    exp_valid = (q.size() != 0) && !stall && !flush_i;
    chk("usage", usage_o, q.size());
    chk("c_q_ready", c_q_ready_o, (q.size() != DEPTH) && !flush_i);
    chk("issue_valid", issue_valid_o, exp_valid);
    chk("fpr_busy", fpr_busy_o, busy);
    if (q.size() > 0) begin
      chk("issue_instr", issue_instr_o, q[0].instr);
      chk("issue_hart", issue_hart_id_o, q[0].hart);
      chk("issue_rs", issue_rs_o, q[0].rs);
    end
    push  = c_q_valid_i && (q.size() != DEPTH) && !flush_i;
    pop   = exp_valid && issue_ready_i;
    bnext = busy;
    if (SbEn && wb_valid_i) bnext[wb_addr_i] = 1'b0;
    if (SbEn && pop && q[0].rd_fp) bnext[q[0].instr[11:7]] = 1'b1;
    @(posedge clk);
    if (flush_i) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(nxt);
    end
    busy = bnext;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    c_q_valid_i = 0; flush_i = 0; issue_ready_i = 0; wb_valid_i = 0; wb_addr_i = '0;
    head_fpr_use_i = '0; head_rd_is_fp_i = 0;
    nxt = mk(0, 0, 0, 0, 3'b000, 1'b0);
    c_q_instr_data_i = nxt.instr; c_q_hart_id_i = nxt.hart; c_q_rs_i = nxt.rs;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", issue_valid_o, 1'b0);
    chk("rst_usage", usage_o, 0);
    chk("rst_busy", fpr_busy_o, 0);
    chk("rst_instr", issue_instr_o, 0);
    chk("rst_hart", issue_hart_id_o, 0);
    chk("rst_rs", issue_rs_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_ready", c_q_ready_o, 1'b1);

    // Fill past capacity with issue blocked, then drain in order.
    c_q_valid_i = 1; issue_ready_i = 0;
    for (int i = 0; i < 5; i++) begin nxt = mk_plain(); tick(); end
    chk("full_usage", usage_o, 4);
    chk("full_ready", c_q_ready_o, 1'b0);
    c_q_valid_i = 0; issue_ready_i = 1;
    repeat (5) tick();
    chk("drained_usage", usage_o, 0);

    // RAW on f3: producer then consumer; consumer waits for writeback of f3.
    c_q_valid_i = 1;
    nxt = mk(5'd3, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1); tick();
    nxt = mk(5'd1, 5'd3, 5'd0, 5'd0, 3'b001, 1'b0); tick();
    c_q_valid_i = 0;
    repeat (3) tick();
    wb_valid_i = 1; wb_addr_i = 5'd3; tick();
    wb_valid_i = 0;
    repeat (2) tick();

    // Set and clear of f5 in the same cycle: set wins.
    c_q_valid_i = 1; nxt = mk(5'd5, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1); tick();
    c_q_valid_i = 0; wb_valid_i = 1; wb_addr_i = 5'd5; tick();
    wb_valid_i = 0;
    chk("set_wins_f5", fpr_busy_o[5], SbEn);
    wb_valid_i = 1; wb_addr_i = 5'd5; tick();
    wb_valid_i = 0;

    // Full buffer with continuous push/pop across pointer wrap; stray writeback to idle f9.
    c_q_valid_i = 1; issue_ready_i = 0;
    for (int i = 0; i < 4; i++) begin nxt = mk_plain(); tick(); end
    issue_ready_i = 1;
    for (int i = 0; i < 12; i++) begin
      nxt = mk_plain();
      wb_valid_i = (i == 5); wb_addr_i = 5'd9;
      tick();
    end
    wb_valid_i = 0;
    chk("stream_usage", usage_o, 3);
    c_q_valid_i = 0;
    repeat (4) tick();

    // Flush with three entries and f7 busy; the flush-cycle push is dropped.
    c_q_valid_i = 1; nxt = mk(5'd7, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1); tick();
    c_q_valid_i = 0; tick();
    issue_ready_i = 0; c_q_valid_i = 1;
    for (int i = 0; i < 3; i++) begin nxt = mk_plain(); tick(); end
    chk("pre_flush_usage", usage_o, 3);
    flush_i = 1; nxt = mk_plain(); tick();
    flush_i = 0; c_q_valid_i = 0;
    chk("flush_usage", usage_o, 0);
    chk("flush_keeps_f7", fpr_busy_o[7], SbEn);
    tick();
    wb_valid_i = 1; wb_addr_i = 5'd7; tick();
    wb_valid_i = 0;

    // Randomized traffic with hazards, writebacks and occasional flushes.
    for (int n = 0; n < 400; n++) begin
      c_q_valid_i   = $urandom_range(0, 3) != 0;
      issue_ready_i = $urandom_range(0, 3) != 0;
      flush_i       = $urandom_range(0, 31) == 0;
      wb_valid_i    = 1'($urandom_range(0, 1));
      wb_addr_i     = 5'($urandom_range(0, 7));
      nxt = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      tick();
    end

    // Asynchronous reset in the middle of a burst.
    flush_i = 0; wb_valid_i = 0; issue_ready_i = 0; c_q_valid_i = 1;
    for (int i = 0; i < 3; i++) begin nxt = mk_plain(); tick(); end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", issue_valid_o, 1'b0);
    chk("arst_usage", usage_o, 0);
    chk("arst_busy", fpr_busy_o, 0);
    chk("arst_instr", issue_instr_o, 0);
    chk("arst_hart", issue_hart_id_o, 0);
    chk("arst_rs", issue_rs_o, 0);
    q.delete();
    busy = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue_ready_i = 1;
    nxt = mk_plain(); tick();
    for (int i = 0; i < 6; i++) begin
      c_q_valid_i = 1'($urandom_range(0, 1));
      nxt = mk_plain();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_ss_issue_buffer.md
FPU_SS_ISSUE_BUFFER -- requirements
Module: fpu_ss_issue_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of offload buffer entries; power of two, >= 2.
REQ-002 Parameter NUM_RS, default 3: integer source operands carried per request; legal values 2 or 3.
REQ-003 Parameter XLEN, default 32: width of each integer operand, instruction word and hart id.
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 c_q_valid_i / c_q_ready_o  in / out  1 / 1  C-request handshake; a push occurs when both are high.
REQ-007 c_q_instr_data_i / c_q_hart_id_i  in  XLEN each  offloaded instruction word and hart id.
REQ-008 c_q_rs_i  in  NUM_RS x XLEN  integer source operands.
REQ-009 flush_i  in  1  discards all buffered, unissued requests.
REQ-010 issue_valid_o / issue_ready_i  out / in  1 / 1  issue handshake toward the FPU; an issue occurs when both are high.
REQ-011 issue_instr_o, issue_hart_id_o, issue_rs_o  out  XLEN, XLEN, NUM_RS x XLEN  head-entry fields.
REQ-012 head_fpr_use_i  in  3  decoder flags: head entry reads FP register rs1 (instr[19:15]), rs2 (instr[24:20]) and rs3 (instr[31:27]).
REQ-013 head_rd_is_fp_i  in  1  decoder flag: head entry writes FP register rd (instr[11:7]).
REQ-014 wb_valid_i / wb_addr_i  in  1 / 5  FP register-file writeback; clears the pending bit of wb_addr_i.
REQ-015 usage_o  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-016 fpr_busy_o  out  32  scoreboard pending bits, one per FP register.

Function
REQ-017 Buffer: circular FIFO with separate read and write pointers of $clog2(DEPTH) bits; pointers wrap from DEPTH-1 to 0.
REQ-018 No fall-through: a pushed entry is visible at the issue port no earlier than the cycle after the push.
REQ-019 c_q_ready_o = (usage_o != DEPTH) and not flush_i.
REQ-020 When full, no push is accepted, even if an issue occurs in the same cycle.
REQ-021 Push and issue in the same cycle, buffer neither full nor empty: usage_o is unchanged and both pointers advance.
REQ-022 Hazard: stall = (head_fpr_use_i[k] and busy[src_k], for any k) or (head_rd_is_fp_i and busy[rd]); stall uses the registered busy bits only.
REQ-023 issue_valid_o = (usage_o != 0) and not stall and not flush_i.
REQ-024 While issue_valid_o is high and issue_ready_i is low, all issue_* outputs SHALL hold stable.
REQ-025 Scoreboard set: on an issue with head_rd_is_fp_i high, busy[rd] is set the next cycle.
REQ-026 Scoreboard clear: wb_valid_i clears busy[wb_addr_i] the next cycle.
REQ-027 If set and clear target the same address in the same cycle, set wins.
REQ-028 wb_valid_i with a non-busy address is ignored and has no side effect.
REQ-029 Flush: usage_o is 0 and both pointers are 0 the next cycle; any same-cycle push and issue are discarded.
REQ-030 Flush does not alter fpr_busy_o; in-flight operations still retire through writeback.
REQ-031 Pop order is strict FIFO order; no entry is reordered.

Reset
REQ-032 Asynchronous assertion of rst_ni clears pointers, usage_o, all busy bits and stored entries.
REQ-033 Reset values: c_q_ready_o=1 (after release), issue_valid_o=0, usage_o=0, fpr_busy_o=0, issue_* data=0.
REQ-034 Reset mid-operation drops all buffered requests and all pending writebacks; nothing is issued in the first cycle after release.

Configuration
REQ-035 Macro FPU_SS_SCOREBOARD_EN.
REQ-036 Defined: the scoreboard and hazard stall per REQ-022 to REQ-028 are present.
REQ-037 Undefined: stall is constant 0, fpr_busy_o is tied to 0, and head_fpr_use_i, head_rd_is_fp_i, wb_valid_i and wb_addr_i are ignored; the FIFO behaviour is unchanged.

Verification
REQ-038 DEPTH=4, issue_ready_i=0, push 5 requests -> 4 accepted, usage_o=4, c_q_ready_o=0 during the 5th; then pop all -> instructions emerge in push order.
REQ-039 Push instr rd=f3 (head_rd_is_fp_i=1), issue; next instr reads f3 -> issue_valid_o=0 until wb_valid_i with wb_addr_i=3, then issue_valid_o=1 the cycle after the clear.
REQ-040 Same cycle: issue sets f5 and wb_valid_i clears f5 -> fpr_busy_o[5]=1 the next cycle.
REQ-041 Full buffer with continuous push and pop over 3xDEPTH cycles -> pointers wrap, no loss or duplication, usage_o constant.
REQ-042 flush_i with usage_o=3 and f7 busy -> usage_o=0 and fpr_busy_o[7] still 1 the next cycle; push in the flush cycle is not stored.
REQ-043 Assert rst_ni low mid-burst -> all outputs take REQ-033 values immediately, without waiting for a clock edge.
